id_ex_pipe_reg: RTL and testbench

Parametrised ID/EX pipeline register with valid/ready handshake, a two-entry skid buffer, synchronous flush, and optional load-use hazard detection. It sits between the decode stage (register file read, sign extend, control unit) and the execute stage (ALU, forwarding mux). Back-pressure from EX does not drop or duplicate instructions. Decode is stalled automatically when a load's destination is needed by the next instruction.

---
 rtl/id_ex_pipe_reg.sv | 83 ++++++++
 tb/tb_id_ex_pipe_reg.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with two-entry skid buffer, flush and
// optional load-use hazard detection (enabled by defining ID_EX_HAZARD_DETECT_EN).
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] rd1_in,
  input  logic [DATA_W-1:0] rd2_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic [REG_AW-1:0] rs_in,
  input  logic [REG_AW-1:0] rt_in,
  input  logic [REG_AW-1:0] rd_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] rd1_out,
  output logic [DATA_W-1:0] rd2_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [REG_AW-1:0] rs_out,
  output logic [REG_AW-1:0] rt_out,
  output logic [REG_AW-1:0] rd_out,
  output logic              hazard_stall
);
  localparam int E_W = CTRL_W + 3 * DATA_W + 3 * REG_AW;
  logic [E_W-1:0]    w_in, r_main, r_skid;
  logic [CTRL_W-1:0] w_ctrl;
  logic              r_main_valid, r_skid_valid, w_accept, w_handoff, w_stall;
  assign w_in = {ctrl_in, rd1_in, rd2_in, imm_in, rs_in, rt_in, rd_in};
  assign {w_ctrl, rd1_out, rd2_out, imm_out, rs_out, rt_out, rd_out} = r_main;
  // an empty slot must look like a bubble to EX, whatever stale control it holds
  assign ctrl_out     = r_main_valid ? w_ctrl : '0;
  assign out_valid    = r_main_valid;
  assign in_ready     = rst_n & ~r_skid_valid & ~w_stall & ~flush;
  assign w_accept     = in_valid & in_ready;
  assign w_handoff    = r_main_valid & out_ready;
  assign hazard_stall = w_stall;
`ifdef ID_EX_HAZARD_DETECT_EN
  logic              r_load_mr;
  logic [REG_AW-1:0] r_load_rt;
  function automatic logic f_match(input logic [REG_AW-1:0] rt_q, rs, rt);
    return (rt_q == rs && rs != '0) || (rt_q == rt && rt != '0);
  endfunction
  assign w_stall = in_valid & ((r_main_valid & w_ctrl[2] & f_match(rt_out, rs_in, rt_in)) |
                               (r_load_mr & f_match(r_load_rt, rs_in, rt_in)));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_mr <= 1'b0;
      r_load_rt <= '0;
    end else if (flush || !w_handoff) begin
      r_load_mr <= 1'b0;
    end else begin
      r_load_mr <= ctrl_out[2];
      r_load_rt <= rt_out;
    end
  end
`else
  assign w_stall = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= '0;
      r_skid       <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      if (w_handoff && r_skid_valid) r_main <= r_skid;
      else if (w_accept && (!r_main_valid || w_handoff)) r_main <= w_in;
      if (w_accept && r_main_valid && !w_handoff) r_skid <= w_in;
      r_main_valid <= r_main_valid ? (!w_handoff || r_skid_valid || w_accept) : w_accept;
      r_skid_valid <= r_skid_valid ? !w_handoff : (w_accept && r_main_valid && !w_handoff);
    end
  end
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: table-driven bench with an in-order scoreboard of accepted beats.
module tb_id_ex_pipe_reg;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, hazard_stall;
  logic [7:0]  ctrl_in = '0, ctrl_out;
  logic [31:0] rd1_in = '0, rd2_in = '0, imm_in = '0, rd1_out, rd2_out, imm_out;
  logic [4:0]  rs_in = '0, rt_in = '0, rd_in = '0, rs_out, rt_out, rd_out;
  typedef struct {
    logic [7:0]  ctrl;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
  } ent_t;
  typedef struct {
    logic       v, o, f;
    logic [7:0] tag;
    logic       rdy, ov;
  } vec_t;
  ent_t sb[$];
  vec_t tbl[24];
  int   checks = 0, errors = 0;

  id_ex_pipe_reg dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_in(ctrl_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .out_valid(out_valid), .out_ready(out_ready),
    .ctrl_out(ctrl_out), .rd1_out(rd1_out), .rd2_out(rd2_out), .imm_out(imm_out),
    .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out), .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", n, a, e);
    end
  endtask

  // One cycle: drive at negedge, check just after, then advance the scoreboard.
  task automatic cyc(input logic v, o, f, input logic [7:0] ctrl, input logic [4:0] rs, rt, rd,
                     input logic [31:0] d, input logic erdy, eov, est, input string nm);
    ent_t e;
    @(negedge clk);
    in_valid = v; out_ready = o; flush = f; ctrl_in = ctrl;
    rs_in = rs; rt_in = rt; rd_in = rd;
    rd1_in = d; rd2_in = d ^ 32'hFFFF0000; imm_in = d + 32'h100;
    #1;
    chk({nm, ".in_ready"}, in_ready, erdy);
    chk({nm, ".out_valid"}, out_valid, eov);
    chk({nm, ".hazard_stall"}, hazard_stall, est);
    if (eov) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s.scoreboard: got empty queue, required a pending beat", nm);
      end else begin
        e = sb[0];
        chk({nm, ".ctrl_out"}, ctrl_out, e.ctrl);
        chk({nm, ".rd1_out"}, rd1_out, e.rd1);
        chk({nm, ".rd2_out"}, rd2_out, e.rd2);
        chk({nm, ".imm_out"}, imm_out, e.imm);
        chk({nm, ".regs_out"}, {rs_out, rt_out, rd_out}, {e.rs, e.rt, e.rd});
      end
    end else chk({nm, ".bubble_ctrl"}, ctrl_out, 8'h00);
    if (f) sb.delete();
    else begin
      if (eov && o && sb.size() > 0) void'(sb.pop_front());
      if (v && erdy) begin
        e = '{ctrl, d, d ^ 32'hFFFF0000, d + 32'h100, rs, rt, rd};
        sb.push_back(e);
      end
    end
  endtask

  initial begin
    tbl[0]  = '{1, 1, 0, 1, 1, 0};
    tbl[1]  = '{1, 1, 0, 2, 1, 1};
    tbl[2]  = '{1, 1, 0, 3, 1, 1};
    tbl[3]  = '{1, 1, 0, 4, 1, 1};
    tbl[4]  = '{1, 1, 0, 5, 1, 1};
    tbl[5]  = '{1, 1, 0, 6, 1, 1};
    tbl[6]  = '{1, 1, 0, 7, 1, 1};
    tbl[7]  = '{1, 1, 0, 8, 1, 1};
    tbl[8]  = '{1, 0, 0, 9, 1, 1};
    tbl[9]  = '{1, 0, 0, 10, 0, 1};
    tbl[10] = '{1, 0, 0, 10, 0, 1};
    tbl[11] = '{1, 1, 0, 10, 0, 1};
    tbl[12] = '{1, 1, 0, 10, 1, 1};
    tbl[13] = '{0, 1, 0, 0, 1, 1};
    tbl[14] = '{0, 1, 0, 0, 1, 0};
    tbl[15] = '{1, 0, 0, 11, 1, 0};
    tbl[16] = '{1, 0, 0, 12, 1, 1};
    tbl[17] = '{1, 0, 1, 13, 0, 1};
    tbl[18] = '{0, 1, 0, 0, 1, 0};
    tbl[19] = '{1, 1, 0, 14, 1, 0};
    tbl[20] = '{0, 1, 0, 0, 1, 1};
    tbl[21] = '{0, 1, 0, 0, 1, 0};
    tbl[22] = '{1, 1, 1, 15, 0, 0};
    tbl[23] = '{0, 1, 0, 0, 1, 0};
    in_valid = 1'b1;
    #3;
    chk("rst.in_ready", in_ready, 1'b0);
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.ctrl_out", ctrl_out, 8'h00);
    chk("rst.data_out", {rd1_out, rd2_out, imm_out}, 96'h0);
    chk("rst.regs_out", {rs_out, rt_out, rd_out}, 15'h0);
    chk("rst.hazard_stall", hazard_stall, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    cyc(1, 1, 0, 8'h80, 0, 0, 0, 32'hA, 1, 0, 0, "beat_a");
    cyc(0, 1, 0, 8'h00, 0, 0, 0, 32'h0, 1, 1, 0, "beat_a_out");
    cyc(0, 1, 0, 8'h00, 0, 0, 0, 32'h0, 1, 0, 0, "beat_a_idle");
    for (int i = 0; i < 24; i++) begin
      automatic vec_t t = tbl[i];
      cyc(t.v, t.o, t.f, {t.tag[3:0], 4'b0011}, 5'd0, 5'd0, t.tag[4:0], {24'h0, t.tag},
          t.rdy, t.ov, 1'b0, $sformatf("vec%0d", i));
    end
`ifdef ID_EX_HAZARD_DETECT_EN
    cyc(1, 1, 0, 8'h07, 5'd1, 5'd5, 5'd5, 32'h100, 1, 0, 0, "lu_lw");
    cyc(1, 1, 0, 8'h81, 5'd5, 5'd6, 5'd7, 32'h200, 0, 1, 1, "lu_add_main");
    cyc(1, 1, 0, 8'h81, 5'd5, 5'd6, 5'd7, 32'h200, 0, 0, 1, "lu_add_ldex");
    cyc(1, 1, 0, 8'h81, 5'd5, 5'd6, 5'd7, 32'h200, 1, 0, 0, "lu_add_acc");
    cyc(0, 1, 0, 8'h00, 5'd0, 5'd0, 5'd0, 32'h0, 1, 1, 0, "lu_add_out");
`else
    cyc(1, 1, 0, 8'h07, 5'd1, 5'd5, 5'd5, 32'h100, 1, 0, 0, "lu_lw");
    cyc(1, 1, 0, 8'h81, 5'd5, 5'd6, 5'd7, 32'h200, 1, 1, 0, "lu_add_b2b");
    cyc(0, 1, 0, 8'h00, 5'd0, 5'd0, 5'd0, 32'h0, 1, 1, 0, "lu_add_out");
`endif
    cyc(1, 1, 0, 8'h07, 5'd0, 5'd0, 5'd3, 32'h300, 1, 0, 0, "r0_lw");
    cyc(1, 1, 0, 8'h81, 5'd0, 5'd0, 5'd4, 32'h400, 1, 1, 0, "r0_add");
    cyc(0, 1, 0, 8'h00, 5'd0, 5'd0, 5'd0, 32'h0, 1, 1, 0, "r0_add_out");
    cyc(0, 1, 0, 8'h00, 5'd0, 5'd0, 5'd0, 32'h0, 1, 0, 0, "r0_idle");
    cyc(1, 0, 0, 8'h21, 5'd0, 5'd0, 5'd1, 32'h55, 1, 0, 0, "mr_beat1");
    cyc(1, 0, 0, 8'h22, 5'd0, 5'd0, 5'd2, 32'h66, 1, 1, 0, "mr_beat2");
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mr.out_valid", out_valid, 1'b0);
    chk("mr.in_ready", in_ready, 1'b0);
    chk("mr.ctrl_out", ctrl_out, 8'h00);
    chk("mr.data_out", {rd1_out, imm_out}, 64'h0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 1, 0, 8'h00, 5'd0, 5'd0, 5'd0, 32'h0, 1, 0, 0, "mr_after");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
